// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   - default widths and the reset PC
//   - fetch_state_t: fetch FSM state (IDLE, RUN)
//   - fetch_entry_t: one prefetch FIFO entry at the default widths
package fetch_pkg;

  localparam int unsigned PC_W_DEF     = 32;
  localparam int unsigned INSTR_W_DEF  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // The top level packs entries as {instr, pc}, which is the same layout
  // as this struct.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous prefetch FIFO, pointer-plus-count implementation.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          write wdata_i at the tail (taken if not full or popping)
//   pop_i           drop the head entry (ignored when empty)
//   flush_i         empty the FIFO; wins over push and pop
//   wdata_i         entry to write
//   full_o, empty_o occupancy flags
//   head_o          entry at the head, read straight from storage registers
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module instr_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // When full, a push is only legal alongside a pop; it then overwrites the
  // slot being popped, which is safe because that entry leaves at this edge.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage owning the program counter.
// Ports:
//   clock, reset    system clock, asynchronous active-low reset
//   fetch_en        allows new ROM fetches (FIFO keeps draining when low)
//   rom_addr        fetch PC, word addressed; ROM answers combinationally
//   rom_data        ROM word for rom_addr
//   instr_out       instruction at the FIFO head
//   instr_pc        PC of instr_out
//   instr_valid     FIFO non-empty
//   instr_ready     core takes the head this cycle
//   branch_taken    redirect request, looked at only on an accept cycle
//   branch_target   redirect PC
//   fetch_count     words pushed into the FIFO since reset (wraps)
// Handshake: a head entry transfers on a rising edge where
// instr_valid & instr_ready; instr_out/instr_pc hold while valid and not
// ready. A taken branch on a transfer flushes the FIFO, drops that cycle's
// push and loads branch_target, giving one bubble.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_W     = PC_W_DEF,
  parameter int unsigned         INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0]     RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int unsigned         DEPTH    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [31:0]        fetch_count
);

  fetch_state_t              state_q;
  logic [PC_W-1:0]           fetch_pc_q;
  logic [PC_W-1:0]           fetch_pc_d;
  logic [31:0]               fetch_count_q;
  logic [31:0]               fetch_count_d;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [INSTR_W+PC_W-1:0]   fifo_head;

  logic                      accept;
  logic                      redirect;
  logic                      push;
  logic                      push_commit;

  assign accept      = instr_valid & instr_ready;
  assign redirect    = accept & branch_taken;
  assign push        = (state_q == RUN) & (~fifo_full | accept);
  // A redirect squashes the wrong-path word fetched in the same cycle.
  assign push_commit = push & ~redirect;

  // Fetch FSM: RUN follows fetch_en with one cycle of delay.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fetch_en)  state_q <= RUN;
        RUN:     if (!fetch_en) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect) begin
      fetch_pc_d = branch_target;
    end else if (push_commit) begin
      fetch_pc_d    = fetch_pc_q + PC_W'(1);
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      fetch_count_q <= 32'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  instr_fifo #(
    .W     (INSTR_W + PC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push_commit),
    .pop_i   (accept),
    .flush_i (redirect),
    .wdata_i ({rom_data, fetch_pc_q}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign rom_addr    = fetch_pc_q;
  assign instr_valid = ~fifo_empty;
  assign instr_out   = fifo_head[PC_W +: INSTR_W];
  assign instr_pc    = fifo_head[PC_W-1:0];
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the ARM_RISC single-cycle core. It replaces the bench-level PC register and owns the program counter. It drives the ROM address, captures ROM words into a small prefetch FIFO, and presents them to the core with a valid/ready handshake. It redirects on `ctrl_branch_out`/`branch_pc_out` from the core and flushes any wrong-path words.

## Interface
Parameters:
- PC_W, 32, program counter / ROM address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_en  in  1  permits new ROM fetches; FIFO still drains when low
- rom_addr  out  PC_W  ROM word address (= fetch PC); ROM returns data combinationally
- rom_data  in  INSTR_W  ROM output word for `rom_addr`
- instr_out  out  INSTR_W  instruction at FIFO head
- instr_pc  out  PC_W  PC of `instr_out`
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  core accepts head this cycle
- branch_taken  in  1  core's branch decision for the instruction being accepted
- branch_target  in  PC_W  redirect PC
- fetch_count  out  32  number of words pushed into the FIFO since reset (wraps)

## Operation
- FSM states: IDLE, RUN.
  - Reset → IDLE.
  - IDLE → RUN when `fetch_en`=1.
  - RUN → IDLE when `fetch_en`=0.
  - In IDLE no push occurs; pops and redirects are still honoured.
- Accept = `instr_valid & instr_ready`. Push = RUN & (not full, or accept this cycle).
- On push: FIFO tail gets {`rom_data`, fetch PC}, and fetch PC ← fetch PC + 1 (word addressed, modulo 2^PC_W; 2^PC_W−1 wraps to 0).
- `branch_taken` is sampled only on an accept cycle; it is ignored otherwise. On accept with `branch_taken`=1:
  - the FIFO is cleared;
  - fetch PC ← `branch_target`;
  - any push that cycle is discarded, so redirect beats push;
  - `fetch_count` is not incremented for the discarded push.
- Simultaneous push and pop while full: allowed, and occupancy is unchanged.
- `instr_out`/`instr_pc` are the registered FIFO head. They are don't-care while `instr_valid`=0 but must not change while `instr_valid`=1 and `instr_ready`=0.
- Reset values:
  - fetch PC = RESET_PC;
  - FIFO empty, `instr_valid`=0;
  - `instr_out`=0, `instr_pc`=0;
  - `fetch_count`=0;
  - state IDLE.
- Reset assertion mid-operation immediately empties the FIFO and drops `instr_valid` (asynchronous).

## Timing
- `rom_addr` is the fetch PC register and is stable for the whole cycle.
- Fetch latency is 1 cycle: a word pushed at edge N is visible with `instr_valid`=1 after edge N.
- After reset release with `fetch_en`=1:
  - edge 1: IDLE→RUN;
  - edge 2: first push (PC=RESET_PC);
  - `instr_valid` is high after edge 2.
- Steady state, `instr_ready`=1: one instruction per cycle, PCs consecutive.
- Branch penalty is 1 bubble cycle. Accept of a branch at edge N leaves the FIFO empty after N. The target is pushed at N+1 and valid after N+1.
- Backpressure: when full and `instr_ready`=0, fetch PC and `rom_addr` hold.
- `branch_taken`/`branch_target` must be valid before the edge of the accept cycle; they may depend combinationally on `instr_out`.

## Structure
- Package `fetch_pkg`:
  - PC_W and INSTR_W defaults;
  - RESET_PC;
  - `fetch_state_t` enum {IDLE, RUN};
  - FIFO entry struct {instr, pc}.
- Sub-module `instr_fifo`: synchronous FIFO, DEPTH entries of width INSTR_W+PC_W.
  - Ports: push, pop, flush, full, empty, head.
  - Pointer-plus-count implementation.
  - Flush has priority over push.
- Top level contains the FSM, fetch PC register, redirect logic and `fetch_count`.

## Test plan
- Reset, `fetch_en`=1, `instr_ready`=1, ROM[i]=i+0x100 → from the third cycle, instr_out=0x100,0x101,… with instr_pc=0,1,…; `fetch_count` increments by 1 per cycle.
- `instr_ready`=0 for 5 cycles after first valid → FIFO fills to 2; `rom_addr` holds at 2; head stays 0x100/PC 0; on release, PCs 0,1,2 are delivered in order with no gap.
- Accept the instruction at PC 3 with `branch_taken`=1 and target 0x40 → PCs 4 and 5 are never delivered, one bubble follows, then instr_pc=0x40,0x41; `fetch_count` is not incremented for the discarded push.
- `branch_taken`=1 while `instr_valid`=1 and `instr_ready`=0 → ignored; the PC sequence continues unchanged.
- PC preset by branch to 0xFFFFFFFF → next delivered PCs are 0xFFFFFFFF, then 0x0.
- `reset` asserted low mid-stream with the FIFO full → `instr_valid`=0 immediately (before the next edge); after release the sequence restarts at RESET_PC and `fetch_count`=0.
